// File: rtl/tcp_pkg.sv
// Shared types and helpers for the TCP transmit path.
// FSM state encoding, counter widths and a constant clog2.
package tcp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_GAP
    } state_e;

    localparam int GAP_W  = 8;
    localparam int WDOG_W = 24;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/tcp_rr_pick.sv
// Combinational round-robin picker: first set request above `last`,
// wrapping to index 0. Returns one-hot grant, its index and any-valid.
module tcp_rr_pick
    import tcp_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic         hi_found;
    logic         lo_found;
    logic [W-1:0] hi_idx;
    logic [W-1:0] lo_idx;

    // Scan downward so the lowest qualifying index is kept in each half
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last)) begin
                    hi_found = 1'b1;
                    hi_idx   = W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = W'(i);
                end
            end
        end
    end

    assign any = hi_found | lo_found;
    assign idx = hi_found ? hi_idx : lo_idx;

    // Decode the chosen index into a one-hot vector
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = any && (idx == W'(i));
        end
    end

endmodule

// File: rtl/tcp_tx_sched.sv
// Frame-level round-robin scheduler for the shared TCP TX path.
// Optional hung-controller watchdog: define TCP_TX_SCHED_WATCHDOG_EN.
module tcp_tx_sched
    import tcp_pkg::*;
#(
    parameter  int DEVICE_NUM  = 4,
    parameter  int GAP_CYCLES  = 2,
    parameter  int WDOG_CYCLES = 4096,
    localparam int SIZE = (clog2(DEVICE_NUM) > 1) ? clog2(DEVICE_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DEVICE_NUM-1:0] req_i,
    input  logic                  wr_allow_i,
    input  logic                  frame_done_i,
    input  logic                  stop_i,
    output logic [DEVICE_NUM-1:0] grant_o,
    output logic                  grant_vld_o,
    output logic [SIZE-1:0]       port_number_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    state_e                state_q, state_d;
    logic [DEVICE_NUM-1:0] req_q;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [SIZE-1:0]       last_q, last_d;
    logic [DEVICE_NUM-1:0] grant_q, grant_d;
    logic                  vld_q, vld_d;
    logic [SIZE-1:0]       port_q, port_d;
    logic                  busy_q, busy_d;
    logic                  timeout_q, timeout_d;

    logic [DEVICE_NUM-1:0] pick_gnt;
    logic [SIZE-1:0]       pick_idx;
    logic                  pick_any;
    logic                  rel;
    logic                  wdog_hit;

    tcp_rr_pick #(
        .N (DEVICE_NUM),
        .W (SIZE)
    ) u_pick (
        .req  (req_q),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef TCP_TX_SCHED_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    assign wdog_hit = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    // Grant-age counter, cleared when a new grant is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_wdog;

    assign wdog_hit    = 1'b0;
    assign unused_wdog = ^WDOG_W'(WDOG_CYCLES);
`endif

    assign rel = frame_done_i | stop_i;

    // Next-state logic for the grant FSM and its registered outputs
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        last_d    = last_q;
        grant_d   = grant_q;
        vld_d     = vld_q;
        port_d    = port_q;
        timeout_d = 1'b0;
`ifdef TCP_TX_SCHED_WATCHDOG_EN
        wdog_d    = wdog_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any && wr_allow_i) begin
                    grant_d = pick_gnt;
                    port_d  = pick_idx;
                    vld_d   = 1'b1;
                    state_d = ST_BUSY;
`ifdef TCP_TX_SCHED_WATCHDOG_EN
                    wdog_d  = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (rel || wdog_hit) begin
                    grant_d   = '0;
                    vld_d     = 1'b0;
                    last_d    = port_q;
                    timeout_d = wdog_hit & ~rel;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(GAP_CYCLES);
                    end
                end
`ifdef TCP_TX_SCHED_WATCHDOG_EN
                else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (stop_i || gap_q <= GAP_W'(1)) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Request sampling, FSM state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            gap_q     <= '0;
            last_q    <= SIZE'(DEVICE_NUM - 1);
            grant_q   <= '0;
            vld_q     <= 1'b0;
            port_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_i;
            gap_q     <= gap_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            vld_q     <= vld_d;
            port_q    <= port_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_vld_o   = vld_q;
    assign port_number_o = port_q;
    assign busy_o        = busy_q;
    assign timeout_o     = timeout_q;

endmodule
